life_ctrl: RTL and testbench
============================

# life_ctrl

Generation controller for the 8x8 Game of Life engine. It sits directly upstream of the combinational `datapath` next-state stage and owns the 64-bit grid register. It loads a fixed seed or an on-chip pseudo-random pattern, presents `grid` to `datapath`, and commits `next_grid` at a programmable generation rate. It also counts generations and halts on a still-life, extinction or a generation limit.

## Interface
- `TICK_DIV`, 1: clock cycles per generation; range 1..65535.
- `MAX_GEN`, 1000: generation limit; range 1..65535.
- `LFSR_INIT`, 64'h0412_6424_0034_3C28: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; load a pattern and begin running; accepted in any state.
- `randomize`  in  1  sampled with `start`: 1 = load LFSR value, 0 = load `seed`.
- `pause`  in  1  level; freezes the tick counter in RUN.
- `seed`  in  64  user seed; row r = bits [8r+7:8r].
- `next_grid`  in  64  from `datapath`, combinational function of `grid`.
- `grid`  out  64  current generation; drives `datapath`.
- `gen_count`  out  16  generations committed since last load.
- `running`  out  1  high in RUN.
- `done`  out  1  high in HOLD.
- `stable`  out  1  HOLD cause: `next_grid == grid`.
- `extinct`  out  1  HOLD cause: `next_grid == 0`.
- `limit`  out  1  HOLD cause: `MAX_GEN` reached.

## Operation
- Reset (`reset` = 0): state IDLE; `grid` = 0, `gen_count` = 0, tick counter = 0, LFSR = `LFSR_INIT`; `running`, `done`, `stable`, `extinct` and `limit` all 0. Reset mid-RUN aborts immediately.
- LFSR: 64-bit Fibonacci, free-running every cycle out of reset. Update: `lfsr <= {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}`. It never reaches zero.
- State IDLE:
  - `start` = 1 loads `grid` with the LFSR value (current register value, pre-advance) or `seed`.
  - The same load clears `gen_count`, the tick counter and all cause flags, then goes to RUN.
- State RUN:
  - If `pause` = 0, the tick counter increments.
  - When the counter equals `TICK_DIV`-1 (a step), the block commits `grid <= next_grid`, sets `gen_count <= gen_count+1` and clears the counter.
  - On that same step it evaluates, using pre-commit values:
    - `stable` = (`next_grid == grid`);
    - `extinct` = (`next_grid == 0`);
    - `limit` = (`gen_count+1 == MAX_GEN`).
  - If any cause is true, the block goes to HOLD. More than one cause may be set.
  - `pause` = 1 holds the counter and `grid`. A step never occurs while paused.
- State HOLD: `grid` and `gen_count` are frozen and the cause flags are held. `start` reloads exactly as from IDLE.
- `start` in RUN: reload and restart (counter and `gen_count` cleared). `start` has priority over a coincident step.
- `start` with `pause` = 1: the load still occurs, and the counter stays at 0 until `pause` drops.
- `gen_count` never exceeds `MAX_GEN`.

## Timing
- Load: `start` sampled at edge N; `grid` is valid and `running` = 1 after edge N.
- First commit occurs at edge N+`TICK_DIV`. Subsequent commits occur every `TICK_DIV` unpaused cycles.
- With `TICK_DIV` = 1, a commit occurs on every RUN cycle.
- Cause flags and `done` rise at the same edge as the terminating commit. `running` falls at that edge.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- Reset: hold `reset` = 0 mid-RUN with `grid` nonzero.
  - Required: `grid` = 0, `gen_count` = 0 and all flags 0 asynchronously.
  - After release, state IDLE with no activity until `start`.
- Blinker: `seed` = 64'h0000_0000_0038_0000, `TICK_DIV` = 1, `MAX_GEN` = 4, bench instantiates `datapath`.
  - Required: `grid` alternates 64'h0000_0000_1010_1000 / 64'h0000_0000_0038_0000.
  - HOLD with `limit` = 1 and `gen_count` = 4 four cycles after load.
- Still life: `seed` = 64'h0000_0000_0006_0600.
  - Required after first commit: `stable` = 1, `done` = 1, `gen_count` = 1, `grid` unchanged.
- Extinction: `seed` = 64'h0000_0000_0010_0000.
  - Required: `extinct` = 1, `grid` = 0, `gen_count` = 1.
- Rate and pause: `TICK_DIV` = 4, blinker seed, `pause` high for 3 cycles mid-interval.
  - Required: commits 4 unpaused cycles apart; the paused cycles are not counted.
- Randomize and restart:
  - `start` with `randomize` = 1 one cycle after reset loads the LFSR value one step past `LFSR_INIT` (i.e. `{LFSR_INIT[62:0], fb}`).
  - A second `start` during RUN reloads and clears `gen_count` to 0.

Source files
------------

// File: rtl/life_ctrl.sv
// Generation controller for the 8x8 Game of Life engine: owns the grid register,
// loads seed/LFSR patterns, paces commits from the datapath and detects halt causes.
module life_ctrl #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned MAX_GEN   = 1000,
  parameter logic [63:0] LFSR_INIT = 64'h0412_6424_0034_3C28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        randomize,
  input  logic        pause,
  input  logic [63:0] seed,
  input  logic [63:0] next_grid,
  output logic [63:0] grid,
  output logic [15:0] gen_count,
  output logic        running,
  output logic        done,
  output logic        stable,
  output logic        extinct,
  output logic        limit
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);
  localparam logic [15:0] MaxGen   = 16'(MAX_GEN);

  state_e      state_q;
  logic [63:0] grid_q;
  logic [63:0] lfsr_q;
  logic [15:0] gen_q;
  logic [15:0] tick_q;
  logic        running_q;
  logic        done_q;
  logic        stable_q;
  logic        extinct_q;
  logic        limit_q;

  logic [63:0] lfsr_d;
  logic        step_d;
  logic        stable_d;
  logic        extinct_d;
  logic        limit_d;

  // Halt causes are judged on pre-commit values so they describe the step being taken.
  assign lfsr_d    = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign step_d    = (tick_q == TickLast);
  assign stable_d  = (next_grid == grid_q);
  assign extinct_d = (next_grid == 64'd0);
  assign limit_d   = ((gen_q + 16'd1) == MaxGen);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grid_q    <= 64'd0;
      lfsr_q    <= LFSR_INIT;
      gen_q     <= 16'd0;
      tick_q    <= 16'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      // A load wins over everything else, including a coincident step.
      if (start) begin
        state_q   <= RUN;
        grid_q    <= randomize ? lfsr_q : seed;
        gen_q     <= 16'd0;
        tick_q    <= 16'd0;
        running_q <= 1'b1;
        done_q    <= 1'b0;
        stable_q  <= 1'b0;
        extinct_q <= 1'b0;
        limit_q   <= 1'b0;
      end else if (state_q == RUN && !pause) begin
        if (step_d) begin
          grid_q    <= next_grid;
          gen_q     <= gen_q + 16'd1;
          tick_q    <= 16'd0;
          stable_q  <= stable_d;
          extinct_q <= extinct_d;
          limit_q   <= limit_d;
          if (stable_d || extinct_d || limit_d) begin
            state_q   <= HOLD;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end else begin
          tick_q <= tick_q + 16'd1;
        end
      end
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign running   = running_q;
  assign done      = done_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign limit     = limit_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl: two instances (fast/limit-4 and divide-by-4) fed by a
// bounded-edge Game of Life model standing in for the datapath.
module tb_life_ctrl;

  localparam logic [63:0] Blinker   = 64'h0000_0000_0038_0000;
  localparam logic [63:0] BlinkerV  = 64'h0000_0000_1010_1000;
  localparam logic [63:0] Block     = 64'h0000_0000_0006_0600;
  localparam logic [63:0] Lonely    = 64'h0000_0000_0010_0000;
  localparam logic [63:0] LfsrStep1 = 64'h0824_C848_0068_7850;

  logic        clk;
  logic        reset;
  logic        start;
  logic        randomize;
  logic        pause;
  logic [63:0] seed;

  logic [63:0] gridA, nextA, gridB, nextB;
  logic [15:0] genA, genB;
  logic        runningA, doneA, stableA, extinctA, limitA;
  logic        runningB, doneB, stableB, extinctB, limitB;

  int checks;
  int failures;

  // Reference next-generation rule; cells beyond the 8x8 edge count as dead.
  function automatic logic [63:0] lifeStep(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              cnt += int'(g[8 * (r + dr) + (c + dc)]);
        n[8 * r + c] = g[8 * r + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  assign nextA = lifeStep(gridA);
  assign nextB = lifeStep(gridB);

  life_ctrl #(.TICK_DIV(1), .MAX_GEN(4)) dutA (
    .clk(clk), .reset(reset), .start(start), .randomize(randomize), .pause(pause),
    .seed(seed), .next_grid(nextA), .grid(gridA), .gen_count(genA), .running(runningA),
    .done(doneA), .stable(stableA), .extinct(extinctA), .limit(limitA)
  );

  life_ctrl #(.TICK_DIV(4), .MAX_GEN(1000)) dutB (
    .clk(clk), .reset(reset), .start(start), .randomize(randomize), .pause(pause),
    .seed(seed), .next_grid(nextB), .grid(gridB), .gen_count(genB), .running(runningB),
    .done(doneB), .stable(stableB), .extinct(extinctB), .limit(limitB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Pulse start for one clock edge; returns at the negedge after the load edge.
  task automatic applyStimulus(input logic randVal, input logic [63:0] seedVal);
    start     = 1'b1;
    randomize = randVal;
    seed      = seedVal;
    @(negedge clk);
    start     = 1'b0;
    randomize = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    start     = 1'b0;
    randomize = 1'b0;
    pause     = 1'b0;
    seed      = 64'd0;

    @(negedge clk);
    checkOutput("reset grid", gridA, 64'd0);
    checkOutput("reset gen", 64'(genA), 64'd0);
    checkOutput("reset flags", {59'd0, runningA, doneA, stableA, extinctA, limitA}, 64'd0);

    // One edge after release the LFSR has advanced once; the next edge loads it.
    reset = 1'b1;
    stepCycles(1);
    applyStimulus(1'b1, 64'd0);
    checkOutput("random load A", gridA, LfsrStep1);
    checkOutput("random load B", gridB, LfsrStep1);
    checkOutput("running after load", 64'(runningB), 64'd1);

    stepCycles(4);
    checkOutput("B first commit gen", 64'(genB), 64'd1);
    applyStimulus(1'b0, Blinker);
    checkOutput("restart gen B", 64'(genB), 64'd0);
    checkOutput("restart grid B", gridB, Blinker);
    checkOutput("restart running B", 64'(runningB), 64'd1);
    checkOutput("blinker load A", gridA, Blinker);

    for (int i = 1; i <= 4; i++) begin
      stepCycles(1);
      checkOutput($sformatf("blinker grid %0d", i), gridA, (i % 2 == 1) ? BlinkerV : Blinker);
      checkOutput($sformatf("blinker gen %0d", i), 64'(genA), 64'(i));
    end
    checkOutput("blinker limit", 64'(limitA), 64'd1);
    checkOutput("blinker done", 64'(doneA), 64'd1);
    checkOutput("blinker running", 64'(runningA), 64'd0);
    checkOutput("blinker stable", 64'(stableA), 64'd0);
    checkOutput("blinker extinct", 64'(extinctA), 64'd0);
    stepCycles(2);
    checkOutput("hold grid frozen", gridA, Blinker);
    checkOutput("hold gen frozen", 64'(genA), 64'd4);

    applyStimulus(1'b0, Blinker);
    stepCycles(2);
    pause = 1'b1;
    stepCycles(3);
    checkOutput("paused no commit", gridB, Blinker);
    pause = 1'b0;
    stepCycles(1);
    checkOutput("tick3 no commit", gridB, Blinker);
    stepCycles(1);
    checkOutput("pause commit grid", gridB, BlinkerV);
    checkOutput("pause commit gen", 64'(genB), 64'd1);
    stepCycles(3);
    checkOutput("interval no commit", gridB, BlinkerV);
    stepCycles(1);
    checkOutput("second commit grid", gridB, Blinker);
    checkOutput("second commit gen", 64'(genB), 64'd2);

    applyStimulus(1'b0, Block);
    stepCycles(1);
    checkOutput("still stable", 64'(stableA), 64'd1);
    checkOutput("still done", 64'(doneA), 64'd1);
    checkOutput("still gen", 64'(genA), 64'd1);
    checkOutput("still grid", gridA, Block);
    checkOutput("still extinct", 64'(extinctA), 64'd0);

    applyStimulus(1'b0, Lonely);
    checkOutput("reload clears stable", 64'(stableA), 64'd0);
    stepCycles(1);
    checkOutput("extinct flag", 64'(extinctA), 64'd1);
    checkOutput("extinct grid", gridA, 64'd0);
    checkOutput("extinct gen", 64'(genA), 64'd1);
    checkOutput("extinct stable", 64'(stableA), 64'd0);

    applyStimulus(1'b0, Blinker);
    stepCycles(2);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset grid", gridB, 64'd0);
    checkOutput("async reset gen", 64'(genB), 64'd0);
    checkOutput("async reset flags A", {59'd0, runningA, doneA, stableA, extinctA, limitA}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    stepCycles(3);
    checkOutput("idle after reset grid", gridB, 64'd0);
    checkOutput("idle after reset running", 64'(runningB), 64'd0);
    checkOutput("idle after reset gen", 64'(genA), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
